fir_multichannel_serial: RTL and testbench

FIR_MULTICHANNEL_SERIAL -- requirements
Module: fir_multichannel_serial

---
 rtl/fir_multichannel_serial.sv | 162 ++++++++++++++++
 tb/tb_fir_multichannel_serial.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_multichannel_serial.sv
// Multichannel serial FIR: one shared multiply-accumulate walks all taps of the
// selected channel's delay line. There is one result per accepted sample.
module fir_multichannel_serial #(
  parameter  int WIDTH      = 16,
  parameter  int COEF_WIDTH = 16,
  parameter  int LENGTH     = 50,
  parameter  int CHANNELS   = 2,
  parameter  int OUT_WIDTH  = 38,
  localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int ADDR_W     = $clog2(LENGTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      FIR_input,
  input  logic [CH_W-1:0]       input_channel,
  input  logic                  input_valid,
  output logic                  input_ready,
  input  logic                  coef_wr_en,
  input  logic [ADDR_W-1:0]     coef_addr,
  input  logic [COEF_WIDTH-1:0] coef_data,
  output logic                  output_valid,
  output logic [CH_W-1:0]       output_channel,
  output logic [OUT_WIDTH-1:0]  FIR_output
);

  localparam int PROD_W = WIDTH + COEF_WIDTH;
  localparam logic [CH_W:0]     CH_LIMIT   = (CH_W + 1)'(CHANNELS);
  localparam logic [ADDR_W:0]   ADDR_LIMIT = (ADDR_W + 1)'(LENGTH);
  localparam logic [ADDR_W-1:0] LAST_TAP   = ADDR_W'(LENGTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_DONE} state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0]           tap_q;
  logic [CH_W-1:0]             ch_q;
  logic signed [OUT_WIDTH-1:0] acc_q;
  logic signed [OUT_WIDTH-1:0] out_q;
  logic [CH_W-1:0]             out_ch_q;

  logic signed [COEF_WIDTH-1:0] coef_q [LENGTH];
  logic signed [WIDTH-1:0]      tap_data [CHANNELS];

  logic                        in_idle;
  logic                        ch_ok;
  logic                        start;
  logic                        coef_we;
  logic signed [WIDTH-1:0]     x_sel;
  logic signed [COEF_WIDTH-1:0] h_sel;
  logic signed [PROD_W-1:0]    prod;
  logic signed [OUT_WIDTH-1:0] prod_ext;

  assign in_idle = (state_q == S_IDLE);
  assign ch_ok   = ({1'b0, input_channel} < CH_LIMIT);
  // Out-of-range channel tags are consumed (handshake completes) but start nothing.
  assign start   = in_idle && input_valid && ch_ok;
  assign coef_we = in_idle && coef_wr_en && ({1'b0, coef_addr} < ADDR_LIMIT);

  assign x_sel    = tap_data[ch_q];
  assign h_sel    = coef_q[tap_q];
  assign prod     = x_sel * h_sel;
  assign prod_ext = OUT_WIDTH'(prod);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_MAC;
      S_MAC:   if (tap_q == LAST_TAP) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: the live accumulator is shown during DONE, the held copy otherwise.
  always_comb begin
    input_ready    = in_idle;
    output_valid   = (state_q == S_DONE);
    FIR_output     = out_q;
    output_channel = out_ch_q;
    if (state_q == S_DONE) begin
      FIR_output     = acc_q;
      output_channel = ch_q;
    end
  end

  // Accumulator, tap counter and result holding registers
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      tap_q    <= '0;
      ch_q     <= '0;
      out_q    <= '0;
      out_ch_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            acc_q <= '0;
            tap_q <= '0;
            ch_q  <= input_channel;
          end
        end
        S_MAC: begin
          acc_q <= acc_q + prod_ext;
          tap_q <= (tap_q == LAST_TAP) ? '0 : tap_q + 1'b1;
        end
        S_DONE: begin
          out_q    <= acc_q;
          out_ch_q <= ch_q;
        end
        default: ;
      endcase
    end
  end

  // Shared coefficient bank; a write in the accept cycle lands before the first MAC.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < LENGTH; k++) begin
        coef_q[k] <= '0;
      end
    end else if (coef_we) begin
      coef_q[coef_addr] <= coef_data;
    end
  end

  // One delay line per channel, each exposing the tap currently being multiplied.
  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic signed [WIDTH-1:0] line_q [LENGTH];
      logic                    shift_en;

      assign shift_en     = start && (input_channel == CH_W'(gi));
      assign tap_data[gi] = line_q[tap_q];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < LENGTH; k++) begin
            line_q[k] <= '0;
          end
        end else if (shift_en) begin
          line_q[0] <= FIR_input;
          for (int k = 1; k < LENGTH; k++) begin
            line_q[k] <= line_q[k-1];
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_fir_multichannel_serial.sv
// Scoreboard bench for fir_multichannel_serial: a bench-side filter model
// predicts each result, its channel and its arrival cycle.
module tb_fir_multichannel_serial;

  localparam int WIDTH = 16;
  localparam int COEF_WIDTH = 16;
  localparam int L = 50;
  localparam int C = 3;
  localparam int OUT_W = 38;
  localparam int CW = 2;
  localparam int AW = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [WIDTH-1:0]  FIR_input = '0;
  logic [CW-1:0]     input_channel = '0;
  logic              input_valid = 1'b0;
  logic              input_ready;
  logic              coef_wr_en = 1'b0;
  logic [AW-1:0]     coef_addr = '0;
  logic [COEF_WIDTH-1:0] coef_data = '0;
  logic              output_valid;
  logic [CW-1:0]     output_channel;
  logic [OUT_W-1:0]  FIR_output;

  fir_multichannel_serial #(
    .WIDTH(WIDTH), .COEF_WIDTH(COEF_WIDTH), .LENGTH(L), .CHANNELS(C), .OUT_WIDTH(OUT_W)
  ) dut (
    .clk(clk), .rst(rst), .FIR_input(FIR_input), .input_channel(input_channel),
    .input_valid(input_valid), .input_ready(input_ready), .coef_wr_en(coef_wr_en),
    .coef_addr(coef_addr), .coef_data(coef_data), .output_valid(output_valid),
    .output_channel(output_channel), .FIR_output(FIR_output)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    int     ch;
    longint val;
    int     cyc;
  } exp_t;

  exp_t   sb[$];
  exp_t   mon_e;
  longint mx[C][L];
  longint mh[L];
  longint last_out = 0;
  int     last_ch = 0;
  int     last_accept = -1;
  bit     bp_mode = 1'b0;

  task automatic model_clear();
    for (int c = 0; c < C; c++)
      for (int k = 0; k < L; k++) mx[c][k] = 0;
    for (int k = 0; k < L; k++) mh[k] = 0;
  endtask

  task automatic model_accept(input int ch, input longint d, input int acc_cyc);
    exp_t   e;
    longint s;
    if (ch >= C) return;
    for (int k = L - 1; k > 0; k--) mx[ch][k] = mx[ch][k-1];
    mx[ch][0] = d;
    s = 0;
    for (int k = 0; k < L; k++) s += mx[ch][k] * mh[k];
    e.ch = ch;
    e.val = s;
    e.cyc = acc_cyc + L;
    sb.push_back(e);
  endtask

  // Offer one sample; optionally write a coefficient in the same accept cycle.
  task automatic send(input int ch, input longint d, input bit wc = 1'b0,
                      input int ca = 0, input longint cd = 0);
    int n = 0;
    @(negedge clk);
    FIR_input = WIDTH'(d);
    input_channel = CW'(ch);
    input_valid = 1'b1;
    while (!input_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!input_ready) begin
      check_val("ready_timeout", 0, 1);
      input_valid = 1'b0;
      return;
    end
    if (wc) begin
      coef_wr_en = 1'b1;
      coef_addr = AW'(ca);
      coef_data = COEF_WIDTH'(cd);
      if (ca < L) mh[ca] = cd;
    end
    if (bp_mode && last_accept >= 0) check_val("accept_spacing", cyc + 1 - last_accept, L + 2);
    last_accept = cyc + 1;
    model_accept(ch, d, cyc + 1);
    @(posedge clk);
    #1;
    coef_wr_en = 1'b0;
    if (!bp_mode) input_valid = 1'b0;
  endtask

  task automatic write_coef(input int a, input longint d);
    int n = 0;
    @(negedge clk);
    while (!input_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!input_ready) begin
      check_val("coef_ready_timeout", 0, 1);
      return;
    end
    coef_wr_en = 1'b1;
    coef_addr = AW'(a);
    coef_data = COEF_WIDTH'(d);
    if (a < L) mh[a] = d;
    @(posedge clk);
    #1;
    coef_wr_en = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check_val("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    input_valid = 1'b0;
    coef_wr_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    model_clear();
    last_accept = -1;
  endtask

  task automatic check_idle_zero(input string tag);
    check_val({tag, "_ready"}, input_ready, 1);
    check_val({tag, "_valid"}, output_valid, 0);
    check_val({tag, "_out"}, $signed(FIR_output), 0);
    check_val({tag, "_ch"}, output_channel, 0);
  endtask

  // Scoreboard monitor: every strobe must match the oldest prediction.
  always @(negedge clk) begin
    if (output_valid) begin
      if (sb.size() == 0) begin
        check_val("unexpected_valid", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check_val("out_val", $signed(FIR_output), mon_e.val);
        check_val("out_ch", output_channel, mon_e.ch);
        check_val("out_cyc", cyc, mon_e.cyc);
        last_out = $signed(FIR_output);
        last_ch = output_channel;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset();
    check_idle_zero("reset");

    // Impulse response with h[k] = k+1
    for (int k = 0; k < L; k++) write_coef(k, k + 1);
    send(0, 1);
    for (int i = 1; i < L; i++) send(0, 0);
    drain();
    check_val("impulse_last", last_out, L);

    // Channel isolation with all-ones taps
    do_reset();
    for (int k = 0; k < L; k++) write_coef(k, 1);
    for (int i = 0; i < L; i++) begin
      send(0, (i == 0) ? 1 : 0);
      send(1, 100);
    end
    drain();
    check_val("ramp_last", last_out, 5000);
    check_val("ramp_last_ch", last_ch, 1);

    // Full-scale negative samples and coefficients
    do_reset();
    for (int k = 0; k < L; k++) write_coef(k, -32768);
    for (int i = 0; i < L; i++) send(1, -32768);
    drain();
    check_val("fullscale", last_out, 64'sd53687091200);
    repeat (5) @(negedge clk);
    check_val("hold_out", $signed(FIR_output), 64'sd53687091200);
    check_val("hold_ch", output_channel, 1);

    // Reset in the middle of a MAC aborts it
    send(1, 7);
    repeat (10) @(negedge clk);
    do_reset();
    check_idle_zero("midmac");
    repeat (L + 5) @(negedge clk);
    send(0, 1);
    drain();
    check_val("post_reset_impulse", last_out, 0);

    // Discarded channel tag, write during MAC, out-of-range address
    do_reset();
    for (int k = 0; k < L; k++) write_coef(k, 2);
    send(3, 1000);
    check_val("bad_ch_ready", input_ready, 1);
    send(0, 5);
    drain();
    check_val("after_bad_ch", last_out, 10);
    send(0, 3);
    @(negedge clk);
    coef_wr_en = 1'b1;
    coef_addr = AW'(0);
    coef_data = COEF_WIDTH'(99);
    @(negedge clk);
    coef_wr_en = 1'b0;
    drain();
    write_coef(L, 77);
    send(0, 1);
    drain();
    check_val("ignored_writes", last_out, 18);

    // Coefficient write in the accept cycle is used by that sample
    send(0, 4, 1'b1, 1, 10);
    drain();
    check_val("same_cycle_coef", last_out, 34);

    // Continuous input_valid: accepts spaced LENGTH+2
    bp_mode = 1'b1;
    last_accept = -1;
    for (int i = 0; i < 5; i++) send(1, 10 * (i + 1));
    bp_mode = 1'b0;
    input_valid = 1'b0;
    drain();

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
